// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
//   Shared constants and the capture FSM state encoding for the
//   life_scan_capture block and its shift-register sub-module.
//
//   LIFE_CELLS  cells per array = scan-chain length = memory word width
//   LIFE_BANKS  number of memory words written round-robin
// ---------------------------------------------------------------------------
package life_pkg;

  localparam int LIFE_CELLS = 16;
  localparam int LIFE_BANKS = 4;

  // HOLD is reachable only when FRAME_SYNC_EN is defined.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    HOLD   = 2'd2,
    COMMIT = 2'd3
  } capture_state_e;

endpackage

// File: rtl/life_scan_shreg.sv
// ---------------------------------------------------------------------------
// life_scan_shreg
//   CELLS-wide serial-in shift register plus bit counter used to assemble
//   the bits coming off the life array scan chain into one word.
//   New bits enter at the MSB, so after CELLS shifts the first bit shifted
//   in sits in bit 0.
//
// Ports
//   clk    in   1      system clock
//   reset  in   1      synchronous, active-high
//   shift  in   1      shift din in and advance the counter
//   clear  in   1      zero register and counter (start of a capture)
//   din    in   1      serial bit from the array
//   sh     out  CELLS  assembled word
//   last   out  1      counter is on the final bit (count == CELLS-1)
// ---------------------------------------------------------------------------
module life_scan_shreg
  import life_pkg::*;
#(
  parameter int CELLS = LIFE_CELLS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             clear,
  input  logic             din,
  output logic [CELLS-1:0] sh,
  output logic             last
);

  localparam int CNT_W = $clog2(CELLS);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sh    <= '0;
      count <= '0;
    end else if (shift) begin
      sh    <= {din, sh[CELLS-1:1]};
      // Wrap so the counter is ready for the next capture even without clear.
      count <= last ? '0 : count + 1'b1;
    end
  end

  assign last = (count == CNT_W'(CELLS - 1));

endmodule

// File: rtl/life_scan_capture.sv
// ---------------------------------------------------------------------------
// life_scan_capture
//   On request, shifts the whole life array scan chain once while feeding
//   every bit straight back in (so the generation is preserved), assembles
//   the bits into one word and writes it into the Block_Mem selector port
//   that feeds the VGA display. Banks are written round-robin.
//
//   Optional feature macro: FRAME_SYNC_EN
//     defined   - after shifting, wait in HOLD for a frame strobe and write
//                 on the cycle after it, so the display only changes between
//                 frames.
//     undefined - write immediately after shifting; frame is unused.
//
// Ports
//   clk             in   1       system clock
//   reset           in   1       synchronous, active-high
//   scan_start      in   1       one-cycle capture request
//   scan            out  1       scan-shift strobe to the array
//   scan_read_val   in   1       serial bit from array, valid while scan=1
//   scan_write_val  out  1       recirculated bit back into the array
//   scan_write_enb  out  1       enables scan_write_val into the chain
//   frame           in   1       one-cycle frame strobe
//   mem_write_enb   out  1       one-cycle memory write strobe
//   mem_addr        out  ADDR_W  memory word address (current bank)
//   mem_data        out  CELLS   captured word
//   busy            out  1       capture in progress (SHIFT/HOLD/COMMIT)
//   done            out  1       one-cycle pulse with mem_write_enb
//   overrun         out  1       sticky: scan_start seen while busy
//   state_dbg       out  2       current FSM state (capture_state_e)
//
// Handshake: scan_start is a single-cycle request accepted only in IDLE;
// any request while busy (including the COMMIT cycle) is dropped and sets
// overrun. The write is a single-cycle strobe with no back-pressure.
// ---------------------------------------------------------------------------
module life_scan_capture
  import life_pkg::*;
#(
  parameter int CELLS     = LIFE_CELLS,
  parameter int NUM_BANKS = LIFE_BANKS,
  parameter int ADDR_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_start,
  output logic              scan,
  input  logic              scan_read_val,
  output logic              scan_write_val,
  output logic              scan_write_enb,
  input  logic              frame,
  output logic              mem_write_enb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CELLS-1:0]  mem_data,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [1:0]        state_dbg
);

  capture_state_e    state;
  logic [ADDR_W-1:0] bank;
  logic [CELLS-1:0]  sh;
  logic [CELLS-1:0]  word_q;
  logic              last;
  logic              start_accept;

`ifndef FRAME_SYNC_EN
  logic frame_unused;
  assign frame_unused = frame;
`endif

  assign start_accept = (state == IDLE) && scan_start;

  life_scan_shreg #(
    .CELLS (CELLS)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .shift (scan),
    .clear (start_accept),
    .din   (scan_read_val),
    .sh    (sh),
    .last  (last)
  );

  // Recirculation: whatever leaves the chain goes straight back in.
  assign scan_write_enb = scan;
  assign scan_write_val = scan_read_val;

  assign mem_addr  = bank;
  // The shift register is stable in COMMIT; word_q keeps the last written
  // word visible while the next capture reuses the shift register.
  assign mem_data  = (state == COMMIT) ? sh : word_q;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      scan          <= 1'b0;
      busy          <= 1'b0;
      mem_write_enb <= 1'b0;
      done          <= 1'b0;
      bank          <= '0;
      overrun       <= 1'b0;
      word_q        <= '0;
    end else begin
      mem_write_enb <= 1'b0;
      done          <= 1'b0;

      if (scan_start && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (scan_start) begin
            state <= SHIFT;
            scan  <= 1'b1;
            busy  <= 1'b1;
          end
        end

        SHIFT: begin
          if (last) begin
            scan <= 1'b0;
`ifdef FRAME_SYNC_EN
            state <= HOLD;
`else
            state         <= COMMIT;
            mem_write_enb <= 1'b1;
            done          <= 1'b1;
`endif
          end
        end

`ifdef FRAME_SYNC_EN
        HOLD: begin
          if (frame) begin
            state         <= COMMIT;
            mem_write_enb <= 1'b1;
            done          <= 1'b1;
          end
        end
`endif

        COMMIT: begin
          state  <= IDLE;
          busy   <= 1'b0;
          word_q <= sh;
          bank   <= (bank == ADDR_W'(NUM_BANKS - 1)) ? '0 : bank + 1'b1;
        end

        default: begin
          state <= IDLE;
          scan  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_scan_capture.sv
// ---------------------------------------------------------------------------
// tb_life_scan_capture
//   Drives life_scan_capture against a behavioural 16-cell recirculating
//   scan-chain array. Every accepted capture pushes {write cycle, bank,
//   word} into exp_q; a monitor pops and compares on each memory write.
// ---------------------------------------------------------------------------
module tb_life_scan_capture;

  localparam int CELLS = 16;
  localparam int AW    = 2;
  localparam int EW    = 32 + AW + CELLS;

`ifdef FRAME_SYNC_EN
  localparam int WRITE_OFF = 41;
`else
  localparam int WRITE_OFF = 17;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             reset = 1'b1;
  logic             scan_start = 1'b0;
  logic             frame = 1'b0;
  logic             scan;
  logic             scan_read_val;
  logic             scan_write_val;
  logic             scan_write_enb;
  logic             mem_write_enb;
  logic [AW-1:0]    mem_addr;
  logic [CELLS-1:0] mem_data;
  logic             busy;
  logic             done;
  logic             overrun;
  logic [1:0]       state_dbg;

  life_scan_capture dut (
    .clk            (clk),
    .reset          (reset),
    .scan_start     (scan_start),
    .scan           (scan),
    .scan_read_val  (scan_read_val),
    .scan_write_val (scan_write_val),
    .scan_write_enb (scan_write_enb),
    .frame          (frame),
    .mem_write_enb  (mem_write_enb),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun),
    .state_dbg      (state_dbg)
  );

  // Behavioural array: bit 0 leaves the chain, recirculated bit enters at top.
  logic [CELLS-1:0] arr = '0;
  logic             load_en = 1'b0;
  logic [CELLS-1:0] load_val = '0;
  always @(posedge clk) begin
    if (load_en) arr <= load_val;
    else if (scan_write_enb) arr <= {scan_write_val, arr[CELLS-1:1]};
  end
  assign scan_read_val = arr[0];

  // scoreboard state
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  int  bank_exp = 0;
  bit  overrun_exp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!reset && mem_write_enb) begin
      logic [EW-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h cycle=%0d, expected no write",
                 mem_addr, mem_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({32'(cyc), mem_addr, mem_data} !== e || done !== 1'b1) begin
          errors++;
          $display("FAIL mem_write: got cycle=%0d addr=%0d data=%0h done=%0b expected cycle=%0d addr=%0d data=%0h done=1",
                   cyc, mem_addr, mem_data, done, e[EW-1:AW+CELLS], e[AW+CELLS-1:CELLS], e[CELLS-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; scan_start = 1'b0; frame = 1'b0; load_en = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("reset_scan",    64'(scan), 0);
    chk("reset_wenb",    64'(scan_write_enb), 0);
    chk("reset_memwe",   64'(mem_write_enb), 0);
    chk("reset_addr",    64'(mem_addr), 0);
    chk("reset_data",    64'(mem_data), 0);
    chk("reset_busy",    64'(busy), 0);
    chk("reset_done",    64'(done), 0);
    chk("reset_overrun", 64'(overrun), 0);
    chk("reset_state",   64'(state_dbg), 0);
    reset = 1'b0;
    bank_exp = 0;
    overrun_exp = 1'b0;
    step();
  endtask

  // One capture of 'word'. start2: optional second scan_start at that offset.
  // abort_at: assert reset at that offset (0 = no abort).
  task automatic run_capture(input logic [CELLS-1:0] word, input int start2, input int abort_at);
    int c;
    int scan_cnt;
    int busy_cnt;
    bit fin;
    c = 0; scan_cnt = 0; busy_cnt = 0; fin = 1'b0;
    load_val = word;
    load_en  = 1'b1;
    step();
    load_en  = 1'b0;
    for (int k = 0; k < 200 && !fin; k++) begin
      scan_start = (k == 0) || (start2 != 0 && k == start2);
      frame      = (k == 10) || (k == 40);
      reset      = (abort_at != 0 && k == abort_at);
      if (k == 0) begin
        c = cyc;
        if (abort_at == 0) begin
          exp_q.push_back({32'(c + WRITE_OFF), AW'(bank_exp), word});
          bank_exp = (bank_exp + 1) % 4;
        end
      end
      if (start2 >= 1 && start2 <= WRITE_OFF && k == start2) overrun_exp = 1'b1;
      @(negedge clk);
      if (scan) scan_cnt++;
      if (busy) busy_cnt++;
      if (abort_at != 0 && k == abort_at) chk("abort_scan_before", 64'(scan), 1);
      if (abort_at != 0 && k == abort_at + 1) begin
        chk("abort_scan_after", 64'(scan), 0);
        chk("abort_busy_after", 64'(busy), 0);
        chk("abort_addr_after", 64'(mem_addr), 0);
        fin = 1'b1;
      end else if (abort_at == 0 && k > 0 && !busy) begin
        fin = 1'b1;
      end
      step();
    end
    scan_start = 1'b0;
    frame      = 1'b0;
    reset      = 1'b0;
    if (abort_at != 0) begin
      bank_exp = 0;
      overrun_exp = 1'b0;
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout: busy still high after 200 cycles, expected idle");
    end else if (abort_at == 0) begin
      chk("scan_cycles",  64'(scan_cnt), CELLS);
      chk("busy_cycles",  64'(busy_cnt), WRITE_OFF);
      chk("array_intact", 64'(arr), 64'(word));
      chk("overrun",      64'(overrun), 64'(overrun_exp));
    end
  endtask

  // test sequence
  initial begin
    logic [CELLS-1:0] tbl[4];
    tbl[0] = 16'h3300; tbl[1] = 16'h33CC; tbl[2] = 16'h0700; tbl[3] = 16'h0000;

    do_reset();

    // single capture with a known pattern
    run_capture(16'h6186, 0, 0);

    // four banks then wrap
    do_reset();
    for (int i = 0; i < 4; i++) run_capture(tbl[i], 0, 0);
    run_capture(16'(($urandom)), 0, 0);

    // second request mid-shift is dropped and sets overrun
    do_reset();
    run_capture(16'(($urandom)), 5, 0);
    run_capture(16'(($urandom)), 0, 0);
    do_reset();

    // reset in the middle of shifting aborts without a write
    run_capture(16'(($urandom)), 0, 0);
    run_capture(16'(($urandom)), 0, 8);
    run_capture(16'(($urandom)), 0, 0);

    // request on the commit cycle counts as overrun, bank advances once
    run_capture(16'(($urandom)), WRITE_OFF, 0);
    run_capture(16'(($urandom)), 0, 0);

    // random words, random gaps
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) step();
      run_capture(16'(($urandom)), 0, 0);
    end

    repeat (3) step();
    chk("queue_empty", 64'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
